// File: rtl/load_data_ext_if.sv
// Load-return bus bundle: issue side, memory read-return side and W-stage result side.
// master drives the requests and memory return; slave is the load_data_ext unit.
interface load_data_ext_if;
  logic        Req;
  logic        ld_valid;
  logic [1:0]  A;
  logic [2:0]  DE_op;
  logic        m_rdata_valid;
  logic [31:0] m_rdata;
  logic        Dout_ready;
  logic [31:0] Dout;
  logic        Dout_valid;
  logic        busy;
  logic        bus_err;
  logic        AdEL;

  modport master (
    output Req, ld_valid, A, DE_op, m_rdata_valid, m_rdata, Dout_ready,
    input  Dout, Dout_valid, busy, bus_err, AdEL
  );

  modport slave (
    input  Req, ld_valid, A, DE_op, m_rdata_valid, m_rdata, Dout_ready,
    output Dout, Dout_valid, busy, bus_err, AdEL
  );
endinterface

// File: rtl/load_data_ext.sv
// Load-return path: latches offset/type at issue, waits for the read-return, extends and holds the result.
// Optional misaligned-load detection (AdEL) is built when LOAD_ALIGN_CHECK_EN is defined.
module load_data_ext #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  load_data_ext_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [1:0]  a_q, a_nx;
  logic [2:0]  op_q, op_nx;
  logic [7:0]  cnt_q, cnt_nx;
  logic [31:0] dout_q, dout_nx;
  logic        vld_q, vld_nx;
  logic        busy_q, busy_nx;
  logic        berr_q, berr_nx;
  logic        adel_q, adel_nx;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] op);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'b001:  r = $signed({24'd0, b});
      3'b010:  r = 32'(b);
      3'b011:  r = $signed({16'd0, h});
      3'b100:  r = 32'(h);
      default: r = $signed(w);
    endcase
    return r;
  endfunction

`ifdef LOAD_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] a, input logic [2:0] op);
    case (op)
      3'b001, 3'b010: return 1'b0;
      3'b011, 3'b100: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction
`endif

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    op_nx    = op_q;
    cnt_nx   = cnt_q;
    dout_nx  = dout_q;
    vld_nx   = vld_q;
    busy_nx  = busy_q;
    berr_nx  = berr_q;
    adel_nx  = adel_q;
    case (state)
      IDLE: begin
        if (bus.ld_valid && !bus.Req) begin
          a_nx    = bus.A;
          op_nx   = bus.DE_op;
          cnt_nx  = 8'd0;
          busy_nx = 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
          if (misaligned(bus.A, bus.DE_op)) begin
            state_nx = HOLD;
            dout_nx  = 32'd0;
            vld_nx   = 1'b1;
            adel_nx  = 1'b1;
          end else begin
            state_nx = WAIT;
          end
`else
          state_nx = WAIT;
`endif
        end
      end
      WAIT: begin
        // Flush wins over a same-cycle return
        if (bus.Req) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else if (bus.m_rdata_valid) begin
          state_nx = HOLD;
          dout_nx  = extend(bus.m_rdata, a_q, op_q);
          vld_nx   = 1'b1;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          state_nx = HOLD;
          dout_nx  = 32'd0;
          vld_nx   = 1'b1;
          berr_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // Dout keeps its last value after hand-off
        if (bus.Req || bus.Dout_ready) begin
          state_nx = IDLE;
          vld_nx   = 1'b0;
          berr_nx  = 1'b0;
          adel_nx  = 1'b0;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        vld_nx   = 1'b0;
        berr_nx  = 1'b0;
        adel_nx  = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt_q  <= 8'd0;
      dout_q <= 32'd0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      berr_q <= 1'b0;
      adel_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt_q  <= cnt_nx;
      dout_q <= dout_nx;
      vld_q  <= vld_nx;
      busy_q <= busy_nx;
      berr_q <= berr_nx;
      adel_q <= adel_nx;
    end
  end

  always_ff @(posedge clk) begin
    a_q  <= a_nx;
    op_q <= op_nx;
  end

  assign bus.Dout       = dout_q;
  assign bus.Dout_valid = vld_q;
  assign bus.busy       = busy_q;
  assign bus.bus_err    = berr_q;
`ifdef LOAD_ALIGN_CHECK_EN
  assign bus.AdEL       = adel_q;
`else
  assign bus.AdEL       = 1'b0;
`endif

endmodule

// File: tb/tb_load_data_ext.sv
// Directed bench for load_data_ext: vector table for extension/latency plus hold, flush, timeout and reset sequences.
module tb_load_data_ext;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef LOAD_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  load_data_ext_if bus ();

  load_data_ext #(.MAX_WAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a;
    logic [31:0] rdata;
    int          k;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] a);
    bus.ld_valid = 1'b1;
    bus.DE_op    = op;
    bus.A        = a;
    cycle();
    bus.ld_valid = 1'b0;
  endtask

  task automatic consume();
    bus.Dout_ready = 1'b1;
    cycle();
    bus.Dout_ready = 1'b0;
    chk("consume_valid", 32'(bus.Dout_valid), 32'd0);
    chk("consume_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 2'b11, 32'h80AA_BBCC, 1, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{3'b011, 2'b10, 32'h8001_1234, 3, 1'b0, 32'h0000_8001};
    vecs[2]  = '{3'b100, 2'b10, 32'h8001_1234, 3, 1'b0, 32'hFFFF_8001};
    vecs[3]  = '{3'b001, 2'b00, 32'h1234_56F0, 2, 1'b0, 32'h0000_00F0};
    vecs[4]  = '{3'b010, 2'b01, 32'h1234_7F80, 1, 1'b0, 32'h0000_007F};
    vecs[5]  = '{3'b100, 2'b00, 32'h0000_8000, 2, 1'b0, 32'hFFFF_8000};
    vecs[6]  = '{3'b000, 2'b00, 32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{3'b101, 2'b00, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{3'b001, 2'b10, 32'h00AB_0000, 2, 1'b0, 32'h0000_00AB};
    vecs[9]  = '{3'b100, 2'b11, 32'h8001_1234, 1, 1'b1, 32'hFFFF_8001};
    vecs[10] = '{3'b000, 2'b01, 32'h1357_9BDF, 2, 1'b1, 32'h1357_9BDF};

    reset             = 1'b1;
    bus.Req           = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.A             = 2'b00;
    bus.DE_op         = 3'b000;
    bus.m_rdata_valid = 1'b0;
    bus.m_rdata       = 32'd0;
    bus.Dout_ready    = 1'b0;
    repeat (3) cycle();
    chk("rst_dout", bus.Dout, 32'd0);
    chk("rst_valid", 32'(bus.Dout_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_berr", 32'(bus.bus_err), 32'd0);
    chk("rst_adel", 32'(bus.AdEL), 32'd0);
    reset = 1'b0;
    cycle();

    for (int i = 0; i < 11; i++) begin
      bus.m_rdata = vecs[i].rdata;
      issue(vecs[i].op, vecs[i].a);
      if (ALIGN_ON && vecs[i].mis) begin
        chk($sformatf("v%0d_adel_valid", i), 32'(bus.Dout_valid), 32'd1);
        chk($sformatf("v%0d_adel", i), 32'(bus.AdEL), 32'd1);
        chk($sformatf("v%0d_adel_dout", i), bus.Dout, 32'd0);
      end else begin
        chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
        repeat (vecs[i].k - 1) cycle();
        chk($sformatf("v%0d_early_valid", i), 32'(bus.Dout_valid), 32'd0);
        bus.m_rdata_valid = 1'b1;
        cycle();
        bus.m_rdata_valid = 1'b0;
        chk($sformatf("v%0d_valid", i), 32'(bus.Dout_valid), 32'd1);
        chk($sformatf("v%0d_dout", i), bus.Dout, vecs[i].exp);
        chk($sformatf("v%0d_berr", i), 32'(bus.bus_err), 32'd0);
        chk($sformatf("v%0d_adel", i), 32'(bus.AdEL), 32'd0);
      end
      consume();
    end

    // Hold with Dout_ready low for 5 cycles; a second issue is ignored
    bus.m_rdata = 32'hA5A5_5A5A;
    issue(3'b000, 2'b00);
    bus.m_rdata_valid = 1'b1;
    cycle();
    bus.m_rdata_valid = 1'b0;
    bus.m_rdata       = 32'h1111_2222;
    for (int c = 0; c < 5; c++) begin
      bus.ld_valid = (c == 1);
      bus.m_rdata_valid = (c == 2);
      cycle();
      chk("hold_dout", bus.Dout, 32'hA5A5_5A5A);
      chk("hold_valid", 32'(bus.Dout_valid), 32'd1);
      chk("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.ld_valid      = 1'b0;
    bus.m_rdata_valid = 1'b0;
    consume();
    chk("hold_keep_dout", bus.Dout, 32'hA5A5_5A5A);

    // Flush in WAIT, return arrives the next cycle and is dropped
    issue(3'b000, 2'b00);
    bus.Req = 1'b1;
    cycle();
    bus.Req = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    bus.m_rdata_valid = 1'b1;
    bus.m_rdata       = 32'h7777_8888;
    cycle();
    bus.m_rdata_valid = 1'b0;
    repeat (2) begin
      chk("flush_valid", 32'(bus.Dout_valid), 32'd0);
      cycle();
    end
    chk("flush_dout", bus.Dout, 32'hA5A5_5A5A);

    // Req beats a same-cycle return in WAIT
    issue(3'b000, 2'b00);
    bus.Req = 1'b1;
    bus.m_rdata_valid = 1'b1;
    cycle();
    bus.Req = 1'b0;
    bus.m_rdata_valid = 1'b0;
    chk("req_prio_valid", 32'(bus.Dout_valid), 32'd0);
    chk("req_prio_busy", 32'(bus.busy), 32'd0);

    // Timeout: no return for MAX_WAIT cycles
    issue(3'b000, 2'b00);
    repeat (15) cycle();
    chk("to_early_valid", 32'(bus.Dout_valid), 32'd0);
    cycle();
    chk("to_valid", 32'(bus.Dout_valid), 32'd1);
    chk("to_berr", 32'(bus.bus_err), 32'd1);
    chk("to_dout", bus.Dout, 32'd0);
    // Req in HOLD releases like Dout_ready
    bus.Req = 1'b1;
    cycle();
    bus.Req = 1'b0;
    chk("to_flush_valid", 32'(bus.Dout_valid), 32'd0);
    chk("to_flush_berr", 32'(bus.bus_err), 32'd0);
    bus.m_rdata_valid = 1'b1;
    bus.m_rdata       = 32'h9999_AAAA;
    cycle();
    bus.m_rdata_valid = 1'b0;
    cycle();
    chk("late_ret_valid", 32'(bus.Dout_valid), 32'd0);
    chk("late_ret_busy", 32'(bus.busy), 32'd0);

    // Reset mid-HOLD clears every output on the next edge
    bus.m_rdata = 32'h0000_00FF;
    issue(3'b100, 2'b01);
    if (!ALIGN_ON) begin
      bus.m_rdata_valid = 1'b1;
      cycle();
      bus.m_rdata_valid = 1'b0;
      chk("rh_dout_pre", bus.Dout, 32'h0000_00FF);
    end else begin
      chk("rh_adel_pre", 32'(bus.AdEL), 32'd1);
      chk("rh_dout_pre", bus.Dout, 32'd0);
    end
    chk("rh_valid_pre", 32'(bus.Dout_valid), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rh_dout", bus.Dout, 32'd0);
    chk("rh_valid", 32'(bus.Dout_valid), 32'd0);
    chk("rh_busy", 32'(bus.busy), 32'd0);
    chk("rh_adel", 32'(bus.AdEL), 32'd0);
    chk("rh_berr", 32'(bus.bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
